ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: OVF_TRAP, default 1, 1 = signed ALU overflow suppresses writeback/memory side effects and sets ovf_exc; 0 = overflow ignored.
REQ-002 CLK  in  1  system clock, rising-edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 en  in  1  pipeline advance request from hazard control.
REQ-005 flush  in  1  capture a bubble instead of EX inputs.
REQ-006 porto  in  32  ALU result, also data address.
REQ-007 z_flag  in  1  ALU zero flag.
REQ-008 v_flag  in  1  ALU signed-overflow flag.
REQ-009 ovf_chk  in  1  instruction is trapping ADD/SUB.
REQ-010 regwr_in  in  1  register write enable.
REQ-011 wsel_in  in  5  destination register.
REQ-012 memren_in, memwen_in  in  1 each  load/store.
REQ-013 store_in  in  32  store data.
REQ-014 btype_in  in  2  00 none, 01 BEQ, 10 BNE, 11 jump.
REQ-015 btarget_in  in  32  branch/jump target.
REQ-016 halt_in  in  1  HALT instruction.
REQ-017 dhit  in  1  data memory access complete.
REQ-018 dmemload  in  32  load data, valid with dhit.
REQ-019 valid_out  out  1  stage holds a real instruction.
REQ-020 regwr_out  out  1; wsel_out  out  5; wdat_out  out  32  writeback bundle.
REQ-021 dmemREN, dmemWEN  out  1 each; dmemaddr, dmemstore  out  32  memory request.
REQ-022 mem_stall  out  1  stage busy, upstream must hold.
REQ-023 br_taken  out  1; br_target  out  32  resolved control transfer.
REQ-024 ovf_exc  out  1  sticky overflow exception; halt_out  out  1  sticky halt.

Function
REQ-025 Capture occurs on a rising edge iff en=1, mem_stall=0, halt_out=0; otherwise all latched state holds.
REQ-026 Capture with flush=1 loads a bubble: valid 0, all control bits 0, data fields don't-care; flush without capture is ignored.
REQ-027 Capture with flush=0 latches all inputs and sets valid_out=1.
REQ-028 Overflow at capture (OVF_TRAP=1, ovf_chk=1, v_flag=1): latched regwr/memren/memwen forced 0, ovf_exc set, stays 1 until reset.
REQ-029 br_taken = valid & (btype 01 & latched z | btype 10 & ~latched z | btype 11); br_target = latched btarget_in; both hold with the stage.
REQ-030 FSM states IDLE, REQ, DONE; reset to IDLE.
REQ-031 Any state, capture of valid op with memren|memwen (after REQ-028) -> REQ; capture of anything else -> IDLE.
REQ-032 REQ: mem_stall=1; dmemWEN=latched memwen; dmemREN=latched memren & ~memwen (store wins if both).
REQ-033 REQ with dhit=1 -> DONE same edge; load register captures dmemload if load.
REQ-034 DONE: dmemREN=dmemWEN=0, mem_stall=0; holds until next capture.
REQ-035 dhit outside REQ is ignored.
REQ-036 dmemaddr = latched porto; dmemstore = latched store_in, stable throughout REQ.
REQ-037 wdat_out = load register if latched memren, else latched porto; wsel_out = latched wsel.
REQ-038 regwr_out = valid & latched regwr & ~mem_stall.
REQ-039 halt_in captured sets halt_out sticky; a pending memory op in the halt-capturing cycle is impossible (HALT carries no mem op) but any earlier REQ still completes.
REQ-040 No stage-generated latency beyond one capture edge: outputs reflect captured instruction in the following cycle.

Reset
REQ-041 nRST low asynchronously forces: FSM IDLE, all outputs 0 (valid_out, regwr_out, wsel_out, wdat_out, dmemREN/WEN, dmemaddr, dmemstore, mem_stall, br_taken, br_target, ovf_exc, halt_out), load register 0.
REQ-042 Reset during REQ drops the request in the same cycle; no completion on later dhit.

Verification
REQ-043 ALU pass-through: porto=0x0000_0010, regwr=1, wsel=5, en=1 -> next cycle regwr_out=1, wsel_out=5, wdat_out=0x10, mem_stall=0.
REQ-044 Load: memren=1, porto=0x0000_0100, dhit low 3 cycles then high with dmemload=0xDEAD_BEEF -> dmemREN=1, mem_stall=1 for 4 cycles, then wdat_out=0xDEAD_BEEF, regwr_out=1; en ignored while stalled.
REQ-045 Store+load both set: dmemWEN=1, dmemREN=0, dmemstore=store_in held until dhit.
REQ-046 Overflow: ovf_chk=1, v_flag=1, regwr=1 -> regwr_out=0, ovf_exc=1 and stays 1 across 10 further captures; OVF_TRAP=0 -> regwr_out=1, ovf_exc=0.
REQ-047 Branch: btype 01 z=1 -> br_taken=1; btype 10 z=1 -> 0; flush=1 with btype 11 -> br_taken=0, valid_out=0.
REQ-048 Reset mid-REQ then dhit=1 after release -> dmemREN=0, state IDLE, no write-back; halt_in=1 capture -> halt_out=1, later en pulses change nothing.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// Data-memory bus between the EX/MEM pipeline stage (master) and the data memory (slave).
interface ex_mem_stage_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution, overflow trap, sticky halt and a
// three-state data-memory handshake that stalls upstream until the access completes.
module ex_mem_stage #(
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  en,
  input  logic                  flush,
  input  logic [31:0]           porto,
  input  logic                  z_flag,
  input  logic                  v_flag,
  input  logic                  ovf_chk,
  input  logic                  regwr_in,
  input  logic [4:0]            wsel_in,
  input  logic                  memren_in,
  input  logic                  memwen_in,
  input  logic [31:0]           store_in,
  input  logic [1:0]            btype_in,
  input  logic [31:0]           btarget_in,
  input  logic                  halt_in,
  ex_mem_stage_if.master        dmem,
  output logic                  valid_out,
  output logic                  regwr_out,
  output logic [4:0]            wsel_out,
  output logic [31:0]           wdat_out,
  output logic                  mem_stall,
  output logic                  br_taken,
  output logic [31:0]           br_target,
  output logic                  ovf_exc,
  output logic                  halt_out
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        regwr_q, regwr_d;
  logic        memren_q, memren_d;
  logic        memwen_q, memwen_d;
  logic [4:0]  wsel_q, wsel_d;
  logic [31:0] porto_q, porto_d;
  logic [31:0] store_q, store_d;
  logic [1:0]  btype_q, btype_d;
  logic [31:0] btarget_q, btarget_d;
  logic        z_q, z_d;
  logic        ovf_q, ovf_d;
  logic        halt_q, halt_d;
  logic [31:0] load_q, load_d;

  logic capture;
  logic trap;
  logic mem_op;

  always_comb begin
    capture   = en & (state_q != REQ) & ~halt_q;
    // A trapped instruction keeps its slot but loses every architectural side effect.
    trap      = OVF_TRAP & ovf_chk & v_flag & ~flush;
    mem_op    = ~flush & ~trap & (memren_in | memwen_in);

    state_d   = state_q;
    valid_d   = valid_q;
    regwr_d   = regwr_q;
    memren_d  = memren_q;
    memwen_d  = memwen_q;
    wsel_d    = wsel_q;
    porto_d   = porto_q;
    store_d   = store_q;
    btype_d   = btype_q;
    btarget_d = btarget_q;
    z_d       = z_q;
    ovf_d     = ovf_q;
    halt_d    = halt_q;
    load_d    = load_q;

    if (capture) begin
      state_d   = mem_op ? REQ : IDLE;
      valid_d   = ~flush;
      regwr_d   = ~flush & ~trap & regwr_in;
      memren_d  = ~flush & ~trap & memren_in;
      memwen_d  = ~flush & ~trap & memwen_in;
      btype_d   = flush ? 2'b00 : btype_in;
      wsel_d    = wsel_in;
      porto_d   = porto;
      store_d   = store_in;
      btarget_d = btarget_in;
      z_d       = z_flag;
      if (trap)
        ovf_d = 1'b1;
      if (~flush & halt_in)
        halt_d = 1'b1;
    end else if (state_q == REQ && dmem.dhit) begin
      state_d = DONE;
      // Store wins when both enables are set, so only a pure load updates the load register.
      if (memren_q & ~memwen_q)
        load_d = dmem.dmemload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      regwr_q   <= 1'b0;
      memren_q  <= 1'b0;
      memwen_q  <= 1'b0;
      wsel_q    <= '0;
      porto_q   <= '0;
      store_q   <= '0;
      btype_q   <= 2'b00;
      btarget_q <= '0;
      z_q       <= 1'b0;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
      load_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      regwr_q   <= regwr_d;
      memren_q  <= memren_d;
      memwen_q  <= memwen_d;
      wsel_q    <= wsel_d;
      porto_q   <= porto_d;
      store_q   <= store_d;
      btype_q   <= btype_d;
      btarget_q <= btarget_d;
      z_q       <= z_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
      load_q    <= load_d;
    end
  end

  assign mem_stall      = (state_q == REQ);
  assign dmem.dmemWEN   = mem_stall & memwen_q;
  assign dmem.dmemREN   = mem_stall & memren_q & ~memwen_q;
  assign dmem.dmemaddr  = porto_q;
  assign dmem.dmemstore = store_q;

  assign valid_out = valid_q;
  assign regwr_out = valid_q & regwr_q & ~mem_stall;
  assign wsel_out  = wsel_q;
  assign wdat_out  = memren_q ? load_q : porto_q;
  assign br_target = btarget_q;
  assign ovf_exc   = ovf_q;
  assign halt_out  = halt_q;

  always_comb begin
    br_taken = 1'b0;
    if (valid_q) begin
      unique case (btype_q)
        2'b01:   br_taken = z_q;
        2'b10:   br_taken = ~z_q;
        2'b11:   br_taken = 1'b1;
        default: br_taken = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage; a second instance with OVF_TRAP=0 shares all inputs.
module tb_ex_mem_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, flush, z_flag, v_flag, ovf_chk, regwr_in, memren_in, memwen_in, halt_in;
  logic [31:0] porto, store_in, btarget_in;
  logic [4:0]  wsel_in;
  logic [1:0]  btype_in;

  logic        valid_out, regwr_out, mem_stall, br_taken, ovf_exc, halt_out;
  logic [4:0]  wsel_out;
  logic [31:0] wdat_out, br_target;
  logic        valid2, regwr2, stall2, br2, ovf2, halt2;
  logic [4:0]  wsel2;
  logic [31:0] wdat2, brt2;

  int errors = 0;
  int checks = 0;

  ex_mem_stage_if mif ();
  ex_mem_stage_if mif2 ();

  assign mif2.dhit     = mif.dhit;
  assign mif2.dmemload = mif.dmemload;

  always #5 CLK = ~CLK;

  ex_mem_stage dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .porto(porto), .z_flag(z_flag),
    .v_flag(v_flag), .ovf_chk(ovf_chk), .regwr_in(regwr_in), .wsel_in(wsel_in),
    .memren_in(memren_in), .memwen_in(memwen_in), .store_in(store_in), .btype_in(btype_in),
    .btarget_in(btarget_in), .halt_in(halt_in), .dmem(mif.master),
    .valid_out(valid_out), .regwr_out(regwr_out), .wsel_out(wsel_out), .wdat_out(wdat_out),
    .mem_stall(mem_stall), .br_taken(br_taken), .br_target(br_target), .ovf_exc(ovf_exc),
    .halt_out(halt_out)
  );

  ex_mem_stage #(.OVF_TRAP(1'b0)) dut_nt (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .porto(porto), .z_flag(z_flag),
    .v_flag(v_flag), .ovf_chk(ovf_chk), .regwr_in(regwr_in), .wsel_in(wsel_in),
    .memren_in(memren_in), .memwen_in(memwen_in), .store_in(store_in), .btype_in(btype_in),
    .btarget_in(btarget_in), .halt_in(halt_in), .dmem(mif2.master),
    .valid_out(valid2), .regwr_out(regwr2), .wsel_out(wsel2), .wdat_out(wdat2),
    .mem_stall(stall2), .br_taken(br2), .br_target(brt2), .ovf_exc(ovf2),
    .halt_out(halt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    en = 0; flush = 0; z_flag = 0; v_flag = 0; ovf_chk = 0; regwr_in = 0;
    memren_in = 0; memwen_in = 0; halt_in = 0; porto = 0; store_in = 0;
    btarget_in = 0; wsel_in = 0; btype_in = 2'b00;
  endtask

  initial begin
    clear_inputs();
    mif.dhit = 0;
    mif.dmemload = 0;
    nRST = 0;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid_out}, 0);
    chk("rst_regwr", {31'd0, regwr_out}, 0);
    chk("rst_wdat", wdat_out, 0);
    chk("rst_stall", {31'd0, mem_stall}, 0);
    chk("rst_ren", {31'd0, mif.dmemREN}, 0);
    chk("rst_addr", mif.dmemaddr, 0);
    chk("rst_ovf_halt_br", {29'd0, ovf_exc, halt_out, br_taken}, 0);
    nRST = 1;

    // ALU pass-through
    porto = 32'h10; regwr_in = 1; wsel_in = 5; en = 1;
    tick();
    chk("alu_regwr", {31'd0, regwr_out}, 1);
    chk("alu_wsel", {27'd0, wsel_out}, 5);
    chk("alu_wdat", wdat_out, 32'h10);
    chk("alu_stall", {31'd0, mem_stall}, 0);

    // Load with three wait cycles; en stays high and new inputs must be ignored
    memren_in = 1; porto = 32'h100; wsel_in = 7;
    tick();
    porto = 32'h999; memren_in = 0; wsel_in = 9;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ld_ren_c%0d", i), {31'd0, mif.dmemREN}, 1);
      chk($sformatf("ld_stall_c%0d", i), {31'd0, mem_stall}, 1);
      chk($sformatf("ld_regwr_c%0d", i), {31'd0, regwr_out}, 0);
      if (i == 3) begin
        mif.dhit = 1;
        mif.dmemload = 32'hDEAD_BEEF;
      end
      tick();
    end
    mif.dhit = 0;
    en = 0;
    chk("ld_done_stall", {31'd0, mem_stall}, 0);
    chk("ld_done_ren", {31'd0, mif.dmemREN}, 0);
    chk("ld_wdat", wdat_out, 32'hDEAD_BEEF);
    chk("ld_regwr", {31'd0, regwr_out}, 1);
    chk("ld_wsel", {27'd0, wsel_out}, 7);
    chk("ld_addr_held", mif.dmemaddr, 32'h100);

    // Store and load both set: store wins
    clear_inputs();
    memren_in = 1; memwen_in = 1; store_in = 32'hCAFE_F00D; porto = 32'h200; en = 1;
    tick();
    en = 0; store_in = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("st_wen_c%0d", i), {31'd0, mif.dmemWEN}, 1);
      chk($sformatf("st_ren_c%0d", i), {31'd0, mif.dmemREN}, 0);
      chk($sformatf("st_data_c%0d", i), mif.dmemstore, 32'hCAFE_F00D);
      if (i == 1) mif.dhit = 1;
      tick();
    end
    mif.dhit = 0;
    chk("st_done_wen", {31'd0, mif.dmemWEN}, 0);
    chk("st_done_stall", {31'd0, mem_stall}, 0);

    // Overflow trap vs. ignored
    clear_inputs();
    ovf_chk = 1; v_flag = 1; regwr_in = 1; porto = 32'h7; en = 1;
    tick();
    chk("ovf_regwr", {31'd0, regwr_out}, 0);
    chk("ovf_exc", {31'd0, ovf_exc}, 1);
    chk("novf_regwr", {31'd0, regwr2}, 1);
    chk("novf_exc", {31'd0, ovf2}, 0);
    ovf_chk = 0; v_flag = 0;
    for (int i = 0; i < 10; i++) begin
      porto = 32'(i + 32);
      tick();
      chk($sformatf("ovf_sticky_%0d", i), {30'd0, ovf_exc, regwr_out}, 32'h3);
    end
    chk("ovf_last_wdat", wdat_out, 32'd41);

    // Branch resolution
    clear_inputs();
    en = 1; btype_in = 2'b01; z_flag = 1; btarget_in = 32'h400;
    tick();
    chk("beq_taken", {31'd0, br_taken}, 1);
    chk("beq_target", br_target, 32'h400);
    btype_in = 2'b10; z_flag = 1;
    tick();
    chk("bne_z1", {31'd0, br_taken}, 0);
    z_flag = 0;
    tick();
    chk("bne_z0", {31'd0, br_taken}, 1);
    btype_in = 2'b11; flush = 1; regwr_in = 1;
    tick();
    chk("flush_br", {31'd0, br_taken}, 0);
    chk("flush_valid", {31'd0, valid_out}, 0);
    chk("flush_regwr", {31'd0, regwr_out}, 0);

    // Reset in the middle of a load request
    clear_inputs();
    memren_in = 1; regwr_in = 1; porto = 32'h300; en = 1;
    tick();
    en = 0;
    chk("mid_stall", {31'd0, mem_stall}, 1);
    nRST = 0;
    #1;
    chk("mid_rst_ren", {31'd0, mif.dmemREN}, 0);
    chk("mid_rst_stall", {31'd0, mem_stall}, 0);
    chk("mid_rst_ovf", {31'd0, ovf_exc}, 0);
    @(negedge CLK);
    nRST = 1;
    mif.dhit = 1; mif.dmemload = 32'h5555_AAAA;
    tick();
    mif.dhit = 0;
    chk("post_rst_ren", {31'd0, mif.dmemREN}, 0);
    chk("post_rst_stall", {31'd0, mem_stall}, 0);
    chk("post_rst_wb", {30'd0, valid_out, regwr_out}, 0);
    chk("post_rst_wdat", wdat_out, 0);

    // Sticky halt freezes the stage
    clear_inputs();
    halt_in = 1; regwr_in = 1; porto = 32'h55; wsel_in = 3; en = 1;
    tick();
    chk("halt_set", {31'd0, halt_out}, 1);
    halt_in = 0; porto = 32'h66; wsel_in = 4;
    for (int i = 0; i < 3; i++) begin
      en = 1;
      tick();
      en = 0;
      tick();
    end
    chk("halt_sticky", {31'd0, halt_out}, 1);
    chk("halt_wdat", wdat_out, 32'h55);
    chk("halt_wsel", {27'd0, wsel_out}, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
